// File: rtl/game_pkg.sv
// Shared encodings, FSM states and default timing for the reaction game.
package game_pkg;

  localparam int unsigned LFSR_W = 8;
  localparam int unsigned ACT_W  = 4;

  localparam logic [ACT_W-1:0] ACT_0    = 4'b0000;
  localparam logic [ACT_W-1:0] ACT_1    = 4'b0001;
  localparam logic [ACT_W-1:0] ACT_2    = 4'b0010;
  localparam logic [ACT_W-1:0] ACT_3    = 4'b0011;
  localparam logic [ACT_W-1:0] ACT_NONE = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAY,
    ST_GAP,
    ST_OVER,
    ST_WIN
  } state_e;

  localparam int unsigned      DEF_TICKS_PER_WIN     = 30;
  localparam int unsigned      DEF_WIN_STEP          = 5;
  localparam int unsigned      DEF_ACTIONS_PER_LEVEL = 8;
  localparam int unsigned      DEF_NUM_LEVELS        = 4;
  localparam int unsigned      DEF_GAP_TICKS         = 10;
  localparam int unsigned      DEF_MAX_WRONG         = 5;
  localparam logic [LFSR_W-1:0] DEF_LFSR_SEED        = 8'hA5;

  // Fibonacci step for x^8+x^6+x^5+x^4+1 (taps on bits 7,5,4,3).
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit LFSR; the seed must be nonzero or the register locks up.
module lfsr8
  import game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEF_LFSR_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= SEED;
    else        q <= lfsr_next(q);
  end

endmodule

// File: rtl/action_sequencer.sv
// Drives direction prompts, window timing and level progression for the judge,
// and ends the game once the judge's mistake count grows by MAX_WRONG.
module action_sequencer
  import game_pkg::*;
#(
  parameter int unsigned       TICKS_PER_WIN     = DEF_TICKS_PER_WIN,
  parameter int unsigned       WIN_STEP          = DEF_WIN_STEP,
  parameter int unsigned       ACTIONS_PER_LEVEL = DEF_ACTIONS_PER_LEVEL,
  parameter int unsigned       NUM_LEVELS        = DEF_NUM_LEVELS,
  parameter int unsigned       GAP_TICKS         = DEF_GAP_TICKS,
  parameter int unsigned       MAX_WRONG         = DEF_MAX_WRONG,
  parameter logic [LFSR_W-1:0] LFSR_SEED         = DEF_LFSR_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       wrong_time,
  output logic             level,
  output logic [ACT_W-1:0] action,
  output logic [7:0]       count,
  output logic [1:0]       level_num,
  output logic             win_tick,
  output logic             game_over,
  output logic             game_win
);

  localparam int unsigned TICK_W = 8;
  localparam int unsigned WIDX_W = 8;
  localparam int unsigned MIS_W  = 8;

  state_e              state_q, state_n;
  logic [TICK_W-1:0]   tick_q, tick_n;
  logic [WIDX_W-1:0]   widx_q, widx_n;
  logic [MIS_W-1:0]    wrong_base_q, wrong_base_n;
  logic                level_n, win_tick_n, game_over_n, game_win_n;
  logic [ACT_W-1:0]    action_n;
  logic [7:0]          count_n;
  logic [1:0]          level_num_n;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [ACT_W-1:0]    new_act;
  logic [MIS_W-1:0]    mistakes;
  logic                win_end, last_win, lfsr_unused;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_q)
  );

  // Window length shrinks by WIN_STEP each level.
  function automatic logic [TICK_W-1:0] win_len(input logic [1:0] lvl);
    return TICK_W'(TICKS_PER_WIN - WIN_STEP * 32'(lvl));
  endfunction

  assign new_act     = {2'b00, lfsr_q[1:0]};
  assign lfsr_unused = ^lfsr_q[LFSR_W-1:2];
  assign mistakes    = wrong_time - wrong_base_q;
  assign win_end     = (tick_q == win_len(level_num) - TICK_W'(1));
  assign last_win    = (widx_q == WIDX_W'(ACTIONS_PER_LEVEL - 1));

  always_comb begin
    state_n      = state_q;
    tick_n       = tick_q;
    widx_n       = widx_q;
    wrong_base_n = wrong_base_q;
    level_n      = level;
    action_n     = action;
    count_n      = count;
    level_num_n  = level_num;
    game_over_n  = game_over;
    game_win_n   = game_win;
    win_tick_n   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_OVER, ST_WIN: begin
        if (start) begin
          state_n      = ST_PLAY;
          wrong_base_n = wrong_time;
          count_n      = '0;
          level_num_n  = '0;
          tick_n       = '0;
          widx_n       = '0;
          action_n     = new_act;
          level_n      = 1'b1;
          game_over_n  = 1'b0;
          game_win_n   = 1'b0;
        end
      end
      ST_PLAY: begin
        // Mistake limit wins over any window or level boundary this cycle.
        if (mistakes >= MIS_W'(MAX_WRONG)) begin
          state_n     = ST_OVER;
          level_n     = 1'b0;
          action_n    = ACT_NONE;
          game_over_n = 1'b1;
        end else if (win_end) begin
          tick_n  = '0;
          count_n = count + 8'd1;
          if (!last_win) begin
            widx_n   = widx_q + WIDX_W'(1);
            action_n = new_act;
          end else if (level_num == 2'(NUM_LEVELS - 1)) begin
            state_n    = ST_WIN;
            level_n    = 1'b0;
            action_n   = ACT_NONE;
            game_win_n = 1'b1;
          end else begin
            state_n  = ST_GAP;
            level_n  = 1'b0;
            action_n = ACT_NONE;
          end
        end else begin
          tick_n = tick_q + TICK_W'(1);
        end
      end
      ST_GAP: begin
        if (tick_q == TICK_W'(GAP_TICKS - 1)) begin
          state_n     = ST_PLAY;
          level_num_n = level_num + 2'd1;
          tick_n      = '0;
          widx_n      = '0;
          action_n    = new_act;
          level_n     = 1'b1;
        end else begin
          tick_n = tick_q + TICK_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Registered pulse lands on the cycle where tick sits at the window's last value.
    win_tick_n = (state_n == ST_PLAY) && (tick_n == win_len(level_num_n) - TICK_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tick_q       <= '0;
      widx_q       <= '0;
      wrong_base_q <= '0;
      level        <= 1'b0;
      action       <= ACT_NONE;
      count        <= '0;
      level_num    <= '0;
      win_tick     <= 1'b0;
      game_over    <= 1'b0;
      game_win     <= 1'b0;
    end else begin
      state_q      <= state_n;
      tick_q       <= tick_n;
      widx_q       <= widx_n;
      wrong_base_q <= wrong_base_n;
      level        <= level_n;
      action       <= action_n;
      count        <= count_n;
      level_num    <= level_num_n;
      win_tick     <= win_tick_n;
      game_over    <= game_over_n;
      game_win     <= game_win_n;
    end
  end

endmodule

// File: tb/tb_action_sequencer.sv
// Scoreboard bench: each start queues the expected win_tick events of a full game.
module tb_action_sequencer;

  localparam int TPW = 30, STEP = 5, APL = 8, NLV = 4, GAP = 10;
  localparam int HIST = 4096;

  logic       clk, rst_n, start;
  logic [7:0] wrong_time;
  logic       level, win_tick, game_over, game_win;
  logic [3:0] action;
  logic [7:0] count;
  logic [1:0] level_num;

  typedef struct {
    int end_c;
    int st_c;
    int cnt;
    int lvl;
  } win_t;

  win_t       sbq[$];
  win_t       w;
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc;
  logic [7:0] m_lf;
  logic [7:0] hist [HIST];
  logic [7:0] h;

  action_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .wrong_time (wrong_time),
    .level      (level),
    .action     (action),
    .count      (count),
    .level_num  (level_num),
    .win_tick   (win_tick),
    .game_over  (game_over),
    .game_win   (game_win)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] lf_step(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  // Reference LFSR and cycle counter, both restarted by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lf <= 8'hA5;
      cyc  <= 0;
    end else begin
      m_lf <= lf_step(m_lf);
      cyc  <= cyc + 1;
    end
  end

  always @(negedge clk) hist[cyc % HIST] = m_lf;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Called on a negedge; returns at the negedge right after the start edge.
  task automatic pulse_start(output int e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e = cyc;
  endtask

  task automatic push_game(input int e);
    int ws, idx, wl;
    win_t x;
    ws  = e;
    idx = 0;
    for (int lv = 0; lv < NLV; lv++) begin
      wl = TPW - lv * STEP;
      for (int k = 0; k < APL; k++) begin
        x.end_c = ws + wl - 1;
        x.st_c  = ws;
        x.cnt   = idx;
        x.lvl   = lv;
        sbq.push_back(x);
        idx++;
        ws += wl;
      end
      if (lv < NLV - 1) ws += GAP;
    end
  endtask

  task automatic trim(input int c);
    while (sbq.size() > 0 && sbq[sbq.size()-1].end_c > c) void'(sbq.pop_back());
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_level"}, int'(level), 0);
    chk({tag, "_action"}, int'(action), 15);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_level_num"}, int'(level_num), 0);
    chk({tag, "_win_tick"}, int'(win_tick), 0);
    chk({tag, "_game_over"}, int'(game_over), 0);
    chk({tag, "_game_win"}, int'(game_win), 0);
  endtask

  // Pops one expected window per win_tick pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      while (sbq.size() > 0 && sbq[0].end_c < cyc) begin
        chk("wt_missed", cyc, sbq[0].end_c);
        void'(sbq.pop_front());
      end
      if (win_tick) begin
        if (sbq.size() == 0) begin
          chk("wt_unexpected", int'(win_tick), 0);
        end else begin
          w = sbq.pop_front();
          h = hist[(w.st_c - 1) % HIST];
          chk("wt_cyc", cyc, w.end_c);
          chk("wt_count", int'(count), w.cnt);
          chk("wt_level_num", int'(level_num), w.lvl);
          chk("wt_action", int'(action), int'(h[1:0]));
          chk("wt_level", int'(level), 1);
        end
      end
    end
  end

  initial begin
    int e, d;
    rst_n = 1'b0;
    start = 1'b0;
    wrong_time = 8'd0;
    #12;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(3);

    // Full game, no mistakes, with ignored starts in PLAY and GAP.
    pulse_start(e);
    push_game(e);
    chk("t1_level", int'(level), 1);
    chk("t1_count0", int'(count), 0);
    wait_cyc(e + 100);
    pulse_start(d);
    wait_cyc(e + 243);
    pulse_start(d);
    wait_cyc(e + 245);
    chk("gap_level", int'(level), 0);
    chk("gap_action", int'(action), 15);
    chk("gap_level_num", int'(level_num), 0);
    wait_cyc(e + 250);
    chk("l1_level", int'(level), 1);
    chk("l1_level_num", int'(level_num), 1);
    wait_cyc(e + 750);
    chk("win_game_win", int'(game_win), 1);
    chk("win_count", int'(count), 32);
    chk("win_level", int'(level), 0);
    chk("win_action", int'(action), 15);
    chk("win_game_over", int'(game_over), 0);
    chk("t1_sb_empty", sbq.size(), 0);

    // Restart from WIN with a nonzero baseline, then exceed the limit mid-window.
    wrong_time = 8'd3;
    pulse_start(e);
    push_game(e);
    chk("t2_game_win_clr", int'(game_win), 0);
    chk("t2_count0", int'(count), 0);
    wait_cyc(e + 35);
    wrong_time = 8'd7;
    wait_cyc(e + 38);
    chk("t2_four_mistakes", int'(level), 1);
    wait_cyc(e + 40);
    wrong_time = 8'd8;
    trim(e + 40);
    wait_cyc(e + 41);
    chk("t2_over", int'(game_over), 1);
    chk("t2_level", int'(level), 0);
    chk("t2_action", int'(action), 15);
    chk("t2_count", int'(count), 1);
    chk("t2_sb_empty", sbq.size(), 0);

    // Restart from OVER; limit hit on the last window of level 0 beats GAP.
    pulse_start(e);
    push_game(e);
    chk("t3_game_over_clr", int'(game_over), 0);
    chk("t3_count0", int'(count), 0);
    wait_cyc(e + 239);
    wrong_time = 8'd13;
    trim(e + 239);
    wait_cyc(e + 240);
    chk("t3_over", int'(game_over), 1);
    chk("t3_count", int'(count), 7);
    chk("t3_level", int'(level), 0);
    chk("t3_level_num", int'(level_num), 0);
    chk("t3_sb_empty", sbq.size(), 0);

    // Modulo mistake count; an increase during GAP only bites once PLAY resumes.
    wrong_time = 8'd253;
    pulse_start(e);
    push_game(e);
    wait_cyc(e + 10);
    wrong_time = 8'd1;
    wait_cyc(e + 20);
    chk("t4_wrap_four", int'(game_over), 0);
    wait_cyc(e + 243);
    wrong_time = 8'd2;
    trim(e + 243);
    wait_cyc(e + 249);
    chk("t4_gap_level", int'(level), 0);
    chk("t4_gap_no_over", int'(game_over), 0);
    wait_cyc(e + 250);
    chk("t4_play_level", int'(level), 1);
    chk("t4_play_level_num", int'(level_num), 1);
    wait_cyc(e + 251);
    chk("t4_over", int'(game_over), 1);
    chk("t4_count", int'(count), 8);
    chk("t4_sb_empty", sbq.size(), 0);

    // Asynchronous reset in the middle of a game.
    pulse_start(e);
    push_game(e);
    wait_cyc(e + 100);
    #2 rst_n = 1'b0;
    #1 chk_idle_outputs("midreset");
    sbq.delete();
    #1 rst_n = 1'b1;
    @(negedge clk);
    wait_cyc(10);
    chk("post_reset_level", int'(level), 0);
    chk("post_reset_action", int'(action), 15);
    chk("post_reset_count", int'(count), 0);

    // Fresh game after reset exercises the reseeded LFSR.
    pulse_start(e);
    push_game(e);
    wait_cyc(e + 60);
    wrong_time = 8'd7;
    trim(e + 60);
    wait_cyc(e + 61);
    chk("t5_over", int'(game_over), 1);
    chk("t5_count", int'(count), 2);
    chk("t5_sb_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
